feed_fifo: RTL and testbench

FEED_FIFO -- requirements
Module: feed_fifo

---
 rtl/feed_fifo.sv | 111 +++++++++++
 tb/tb_feed_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : feed_fifo
//  Description : First-word-fall-through FIFO with registered ready/valid
//                flags and a saturating counter of accepted words that carry
//                the truncation marker bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module feed_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH:0]             in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 trunc_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] C_CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE   = PTR_W'(1);
    localparam logic [7:0]       C_TRUNC_MAX = 8'hFF;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_trunc_cnt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_marker;

    // Handshake flags come only from the registered occupancy, so neither
    // side's request can ripple combinationally into the other side's flag.
    always_comb begin
        w_in_ready  = (r_count != C_CNT_FULL);
        w_out_valid = (r_count != C_CNT_ZERO);
        w_push      = in_valid  & w_in_ready;
        w_pop       = out_valid & out_ready;
        w_marker    = in_data[WIDTH];
    end

    // Storage array: written on push only, never reset (contents are don't-care
    // once the pointers and count are cleared).
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data[WIDTH-1:0];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of accepted words carrying the truncation marker.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_trunc_cnt <= '0;
        end else if (w_push && w_marker && (r_trunc_cnt != C_TRUNC_MAX)) begin
            r_trunc_cnt <= r_trunc_cnt + 8'd1;
        end
    end

    // Outputs: head word falls through; zero while the FIFO is empty.
    always_comb begin
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
        count     = r_count;
        trunc_cnt = r_trunc_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_feed_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_feed_fifo
//  Description : Self-checking bench for feed_fifo using a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_feed_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH:0]   in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic [7:0]       trunc_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [WIDTH-1:0] q[$];
    int               m_trunc = 0;

    feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .trunc_cnt (trunc_cnt)
    );

    always #5 clock = ~clock;

    // Advance the model by one edge using the pre-edge state, then clock the DUT.
    task automatic tick();
        bit push;
        bit pop;
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(in_data[WIDTH-1:0]);
            if (in_data[WIDTH] && m_trunc < 255) m_trunc++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q.delete();
        m_trunc = 0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (count !== '0)        begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0)     begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (trunc_cnt !== 8'd0)  begin errors++; $display("FAIL reset_trunc got=%0d exp=0", trunc_cnt); end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {1'b0, exp_words[i]};
            tick();
        end
        checks++; if (count !== CNT_W'(4)) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        in_data = {1'b0, 8'h55};
        tick();
        checks++; if (count !== CNT_W'(4)) begin errors++; $display("FAIL fifth_count got=%0d exp=4", count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_words[i]) begin
                errors++; $display("FAIL drain_word%0d got=%h/%0b exp=%h/1", i, out_data, out_valid, exp_words[i]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL drain_empty got=%h/%0b exp=00/0", out_data, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int next_exp = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) in_valid = 1'b0;
            in_data = {1'b0, 8'(i)};
            if (i < 16) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_stall cyc=%0d got=%0b exp=1", i, in_ready); end
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(next_exp) || count !== CNT_W'(1)) begin
                    errors++; $display("FAIL stream_out cyc=%0d got=%h/%0b cnt=%0d exp=%h/1 cnt=1", i, out_data, out_valid, count, next_exp);
                end
                next_exp++;
            end
            tick();
        end
        checks++; if (next_exp !== 16 || count !== '0) begin
            errors++; $display("FAIL stream_end got=%0d words cnt=%0d exp=16 words cnt=0", next_exp, count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = {1'b0, 8'hA0 + 8'(i)};
            tick();
        end
        in_data   = {1'b0, 8'hB5};
        out_ready = 1'b1;
        tick();
        checks++; if (count !== CNT_W'(3) || out_data !== 8'hA1) begin
            errors++; $display("FAIL fullpop_pop got cnt=%0d data=%h exp cnt=3 data=a1", count, out_data);
        end
        out_ready = 1'b0;
        tick();
        checks++; if (count !== CNT_W'(4)) begin errors++; $display("FAIL fullpop_push got=%0d exp=4", count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_data !== q[0]) begin errors++; $display("FAIL fullpop_drain%0d got=%h exp=%h", i, out_data, q[0]); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_truncation();
        logic [WIDTH:0]   words [3] = '{9'h1AB, 9'h0CD, 9'h1EF};
        logic [WIDTH-1:0] exp_out [3] = '{8'hAB, 8'hCD, 8'hEF};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            tick();
        end
        in_valid = 1'b0;
        checks++; if (trunc_cnt !== 8'd2) begin errors++; $display("FAIL trunc_two got=%0d exp=2", trunc_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== exp_out[i]) begin errors++; $display("FAIL trunc_data%0d got=%h exp=%h", i, out_data, exp_out[i]); end
            tick();
        end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = {1'b1, 8'($urandom)};
            tick();
        end
        in_valid = 1'b0;
        checks++; if (trunc_cnt !== 8'd255 || m_trunc != 255) begin
            errors++; $display("FAIL trunc_sat got=%0d exp=255", trunc_cnt);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = {1'b1, 8'h30 + 8'(i)};
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL midrst_pre got=%0d exp=3", count); end
        #2;
        rst_n = 1'b0;
        q.delete();
        m_trunc = 0;
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || trunc_cnt !== 8'd0) begin
            errors++; $display("FAIL midrst_async got cnt=%0d ov=%0b ir=%0b od=%h tc=%0d exp 0/0/1/00/0",
                               count, out_valid, in_ready, out_data, trunc_cnt);
        end
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = {1'b0, 8'h5A};
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++; $display("FAIL midrst_restart got=%h/%0b exp=5a/1", out_data, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_data   = 9'($urandom);
            checks++;
            if (count !== CNT_W'(q.size()) || in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0) ||
                out_data !== ((q.size() != 0) ? q[0] : 8'h00) || trunc_cnt !== 8'(m_trunc)) begin
                errors++;
                $display("FAIL random cyc=%0d got cnt=%0d ir=%0b ov=%0b od=%h tc=%0d exp cnt=%0d od=%h tc=%0d",
                         i, count, in_ready, out_valid, out_data, trunc_cnt, q.size(),
                         (q.size() != 0) ? q[0] : 8'h00, m_trunc);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_truncation();
        test_mid_reset();
        test_random();
        apply_reset();
        #1;
        checks++; if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL final_reset got cnt=%0d ov=%0b exp 0/0", count, out_valid);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
